uart_receiver: RTL and testbench

Receive half of the UART transceiver: deserialises an asynchronous serial line into bytes, using a 16x-oversampled baud tick derived from the system clock. It pairs with the transmitter and uses the same 3-bit baud selection encoding. The block sits between the external RxD pin and the byte consumer. It reports each received byte with a one-cycle valid pulse plus framing and parity error flags.

---
 rtl/uart_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive path: 2-FF line synchroniser, 16x oversampling divider, frame FSM.
// Latency: Rx_VALID rises 1 clk after the stop-bit mid-sample tick.
// Backpressure: none. Each byte is a one-cycle pulse and the consumer must take it then.
//
// Ports:
//   clk          system clock (50 MHz), rising edge
//   reset        asynchronous, active-low
//   Rx_EN        receiver enable; low forces IDLE and clears divider/sample counter
//   RxD          asynchronous serial input, idles high
//   baud_select  3-bit baud code, latched at start detection
//   Rx_DATA      last received byte (loaded at every stop sample)
//   Rx_VALID     one-clk pulse for an error-free frame
//   Rx_FERROR    stop bit sampled low; held until the next start detection
//   Rx_PERROR    even-parity mismatch; held until the next start detection
//
// Build option: define UART_RX_PARITY_EN for an 11-bit frame with an even parity bit.
// Without it the frame is 10 bits and Rx_PERROR is constant 0.

module uart_receiver (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic       RxD,
    input  logic [2:0] baud_select,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_FERROR,
    output logic       Rx_PERROR
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]  state;
    logic        rx_meta;
    logic        rx_sync;
    logic [2:0]  baud_lat;
    logic [15:0] div_cnt;
    logic [15:0] div_max;
    logic        tick;
    logic [3:0]  sample_cnt;
    logic        mid_bit;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;

    // Two-stage synchroniser; both stages reset to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_sync <= rx_meta;
        end
    end

    // Oversampling divider terminal counts for a 50 MHz clock (16 ticks per bit).
    always_comb begin
        div_max = 16'd26;
        case (baud_lat)
            3'b000: div_max = 16'd10416;
            3'b001: div_max = 16'd2603;
            3'b010: div_max = 16'd650;
            3'b011: div_max = 16'd325;
            3'b100: div_max = 16'd162;
            3'b101: div_max = 16'd80;
            3'b110: div_max = 16'd53;
            3'b111: div_max = 16'd26;
            default: div_max = 16'd26;
        endcase
    end

    // The divider only runs while a frame is in progress; in IDLE it sits at 0
    // so the first tick of a frame is a full tick period after start detection.
    assign tick    = (state != S_IDLE) && (div_cnt == div_max);

    // The sample counter is cleared at start detection and wraps every 16 ticks,
    // so the tick that finds it at 7 is the middle of every bit in the frame.
    assign mid_bit = tick && (sample_cnt == 4'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            baud_lat   <= 3'b000;
            div_cnt    <= 16'd0;
            sample_cnt <= 4'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'h00;
            Rx_DATA    <= 8'h00;
            Rx_VALID   <= 1'b0;
            Rx_FERROR  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Rx_PERROR  <= 1'b0;
`endif
        end else begin
            Rx_VALID <= 1'b0;

            if (!Rx_EN) begin
                // Any frame in progress is dropped; result registers keep their values.
                state      <= S_IDLE;
                div_cnt    <= 16'd0;
                sample_cnt <= 4'd0;
            end else begin
                if (state == S_IDLE || tick) begin
                    div_cnt <= 16'd0;
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end

                if (tick) begin
                    sample_cnt <= sample_cnt + 4'd1;
                end

                case (state)
                    S_IDLE: begin
                        if (!rx_sync) begin
                            baud_lat   <= baud_select;
                            sample_cnt <= 4'd0;
                            Rx_FERROR  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            Rx_PERROR  <= 1'b0;
`endif
                            state      <= S_START;
                        end
                    end

                    S_START: begin
                        if (mid_bit) begin
                            if (rx_sync) begin
                                // Line back high at mid start bit: a glitch, not a frame.
                                state <= S_IDLE;
                            end else begin
                                bit_idx <= 3'd0;
                                state   <= S_DATA;
                            end
                        end
                    end

                    S_DATA: begin
                        if (mid_bit) begin
                            // LSB arrives first, so shift in from the top.
                            shift_reg <= {rx_sync, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (mid_bit) begin
                            // Even parity: data bits plus parity bit must XOR to 0.
                            if ((^shift_reg) ^ rx_sync) begin
                                Rx_PERROR <= 1'b1;
                            end
                            state <= S_STOP;
                        end
                    end
`endif

                    S_STOP: begin
                        if (mid_bit) begin
                            Rx_DATA <= shift_reg;
                            if (!rx_sync) begin
                                Rx_FERROR <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            if (rx_sync && !Rx_PERROR) begin
                                Rx_VALID <= 1'b1;
                            end
`else
                            if (rx_sync) begin
                                Rx_VALID <= 1'b1;
                            end
`endif
                            // Back to IDLE at mid stop bit so a following start edge
                            // that arrives right after the stop bit is not missed.
                            state <= S_IDLE;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign Rx_PERROR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: the driver serialises frames onto RxD and
// pushes the expected result; a monitor pops and compares whenever the receiver
// reports a frame (Rx_VALID pulse or a rising error flag).

module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       Rx_EN;
    logic       RxD;
    logic [2:0] baud_select;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_FERROR;
    logic       Rx_PERROR;

    uart_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .Rx_EN       (Rx_EN),
        .RxD         (RxD),
        .baud_select (baud_select),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_FERROR   (Rx_FERROR),
        .Rx_PERROR   (Rx_PERROR)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t       sb_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cur_bit_clks;
    logic [7:0] last_data;

    // Baud table: clocks per 1/16 bit at 50 MHz.
    function automatic int tick_clks(input logic [2:0] b);
        case (b)
            3'b000: return 10417;
            3'b001: return 2604;
            3'b010: return 651;
            3'b011: return 326;
            3'b100: return 163;
            3'b101: return 81;
            3'b110: return 54;
            default: return 27;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual data=0x%0h valid=%0b ferr=%0b perr=%0b expected none at %0t",
                     Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, $time);
        end else begin
            e = sb_q.pop_front();
            check("frame_data",  {24'd0, Rx_DATA},   {24'd0, e.data});
            check("frame_valid", {31'd0, Rx_VALID},  {31'd0, e.valid});
            check("frame_ferr",  {31'd0, Rx_FERROR}, {31'd0, e.ferr});
            check("frame_perr",  {31'd0, Rx_PERROR}, {31'd0, e.perr});
        end
    endtask

    // Monitor: a parity error is flagged one bit before the byte is loaded, so
    // that case waits one bit time before comparing the finished frame.
    initial begin
        logic prev_f;
        logic prev_p;
        prev_f = 1'b0;
        prev_p = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (Rx_VALID) begin
                    sb_compare();
                    @(negedge clk);
                    check("valid_one_cycle", {31'd0, Rx_VALID}, 32'd0);
                end else if (Rx_FERROR && !prev_f) begin
                    sb_compare();
                end else if (Rx_PERROR && !prev_p) begin
                    repeat (cur_bit_clks + 1) @(negedge clk);
                    sb_compare();
                end
            end
            prev_f = Rx_FERROR;
            prev_p = Rx_PERROR;
        end
    end

    task automatic idle_bits(input int n);
        RxD = 1'b1;
        repeat (n * cur_bit_clks) @(posedge clk);
    endtask

    // mode 0: plain frame; 1: baud_select changed mid-frame; 2: Rx_EN dropped at data bit 4.
    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_bit, input int mode);
        logic [10:0] fr;
        int          nb;
        exp_t        e;
        logic [2:0]  saved_baud;
        saved_baud = baud_select;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = d;
        nb = 9;
        if (PAR_EN) begin
            fr[9] = par_ok ? (^d) : ~(^d);
            nb = 10;
        end
        fr[nb] = stop_bit;
        nb = nb + 1;

        e.data  = d;
        e.ferr  = !stop_bit;
        e.perr  = PAR_EN && !par_ok;
        e.valid = !e.ferr && !e.perr;
        if (mode != 2) begin
            sb_q.push_back(e);
            last_data = d;
        end

        for (int i = 0; i < nb; i++) begin
            if (mode == 1 && i == 3) baud_select = 3'b000;
            if (mode == 2 && i == 5) Rx_EN = 1'b0;
            RxD = fr[i];
            if (i == nb - 1 && !stop_bit) begin
                // Hold the bad stop bit just past its middle, then release the line.
                repeat (cur_bit_clks * 9 / 16) @(posedge clk);
                RxD = 1'b1;
                repeat (cur_bit_clks - cur_bit_clks * 9 / 16) @(posedge clk);
            end else begin
                repeat (cur_bit_clks) @(posedge clk);
            end
        end
        RxD = 1'b1;
        if (mode == 1) baud_select = saved_baud;
        if (mode == 2) Rx_EN = 1'b1;
    endtask

    task automatic set_baud(input logic [2:0] b);
        baud_select  = b;
        cur_bit_clks = 16 * tick_clks(b);
    endtask

    initial begin
        logic [7:0] rd;
        int         kind;

        reset = 1'b0;
        Rx_EN = 1'b0;
        RxD   = 1'b1;
        last_data = 8'h00;
        set_baud(3'b111);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_data",  {24'd0, Rx_DATA},   32'h00);
        check("reset_valid", {31'd0, Rx_VALID},  32'd0);
        check("reset_ferr",  {31'd0, Rx_FERROR}, 32'd0);
        check("reset_perr",  {31'd0, Rx_PERROR}, 32'd0);

        @(posedge clk);
        reset = 1'b1;
        Rx_EN = 1'b1;
        idle_bits(1);

        send_frame(8'h55, 1'b1, 1'b1, 0);
        idle_bits(1);
        send_frame(8'hA3, 1'b0, 1'b1, 0);
        idle_bits(1);
        check("perr_held", {31'd0, Rx_PERROR}, {31'd0, PAR_EN});
        send_frame(8'h0F, 1'b1, 1'b1, 0);
        idle_bits(1);
        check("perr_cleared", {31'd0, Rx_PERROR}, 32'd0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        idle_bits(1);

        // Short low glitch: 3/16 of a bit, must be rejected at mid start bit.
        RxD = 1'b0;
        repeat (cur_bit_clks * 3 / 16) @(posedge clk);
        RxD = 1'b1;
        idle_bits(1);
        @(negedge clk);
        check("glitch_data_held", {24'd0, Rx_DATA},   {24'd0, last_data});
        check("glitch_ferr",      {31'd0, Rx_FERROR}, 32'd0);

        // Frame discarded by Rx_EN going low part way through.
        send_frame(8'hC3, 1'b1, 1'b1, 2);
        idle_bits(1);
        @(negedge clk);
        check("en_drop_data_held", {24'd0, Rx_DATA}, {24'd0, last_data});

        // Back-to-back frames with no idle gap.
        send_frame(8'h12, 1'b1, 1'b1, 0);
        send_frame(8'h34, 1'b1, 1'b1, 0);
        idle_bits(1);

        // Reset in the middle of data bit 4 of a partial frame.
        rd = 8'h5A;
        RxD = 1'b0;
        repeat (cur_bit_clks) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            RxD = rd[i];
            repeat (cur_bit_clks) @(posedge clk);
        end
        RxD = rd[4];
        repeat (cur_bit_clks / 2) @(posedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset_data",  {24'd0, Rx_DATA},   32'h00);
        check("midreset_valid", {31'd0, Rx_VALID},  32'd0);
        check("midreset_ferr",  {31'd0, Rx_FERROR}, 32'd0);
        check("midreset_perr",  {31'd0, Rx_PERROR}, 32'd0);
        last_data = 8'h00;
        RxD = 1'b1;
        @(posedge clk);
        reset = 1'b1;
        idle_bits(1);
        send_frame(8'h7E, 1'b1, 1'b1, 0);
        idle_bits(1);

        // Different rate, with baud_select disturbed mid-frame (latched copy must hold).
        set_baud(3'b110);
        send_frame(8'h96, 1'b1, 1'b1, 1);
        idle_bits(1);
        set_baud(3'b111);
        idle_bits(1);

        // Randomised frames: good, parity error (parity build only) or framing error.
        for (int n = 0; n < 2; n++) begin
            rd   = 8'($urandom);
            kind = $urandom_range(0, 2);
            send_frame(rd, !(kind == 1), !(kind == 2), 0);
            idle_bits(1);
        end

        idle_bits(1);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
